// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-master round-robin arbiter in front of a single-port
// on-chip RAM (1-cycle read latency). The winner of each cycle is accepted with
// zero wait and drives the RAM directly. A registered {valid, owner} tag steers
// the returning read data to the master that issued the read.
// Optional feature macro: ONCHIP_MEM_ARBITER_RANGE_CHECK_EN. It blocks accesses
// at or above DEPTH and returns 32'hDEADBEEF for such reads. It also provides a
// sticky range_err output.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5120
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
`ifdef ONCHIP_MEM_ARBITER_RANGE_CHECK_EN
  ,
  output logic                  range_err
`endif
);

  localparam int BE_W = DATA_W / 8;

  logic              req0;
  logic              req1;
  logic              grant0;
  logic              grant1;
  logic              acc_valid;
  logic              acc_write;
  logic              acc_read;
  logic              acc_oor;
  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;
  logic [DATA_W-1:0] ret_data;

  // last_grant_reg = 1 means m1 won most recently, so m0 wins the next tie
  logic last_grant_reg;
  logic tag_valid_reg;
  logic tag_owner_reg;

  // Arbitration: a lone requester wins; on a tie the non-last winner wins.
  // Holding reset low suppresses every grant, so all masters see waitrequest.
  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    grant0 = reset_n & req0 & (~req1 | last_grant_reg);
    grant1 = reset_n & req1 & ~grant0;
  end

  // Mux the winning master onto the RAM-side request fields
  always_comb begin
    sel_address    = '0;
    sel_byteenable = '0;
    sel_writedata  = '0;
    acc_write      = 1'b0;
    if (grant0) begin
      sel_address    = m0_address;
      sel_byteenable = m0_byteenable;
      sel_writedata  = m0_writedata;
      acc_write      = m0_write;
    end else if (grant1) begin
      sel_address    = m1_address;
      sel_byteenable = m1_byteenable;
      sel_writedata  = m1_writedata;
      acc_write      = m1_write;
    end
    acc_valid = grant0 | grant1;
    // Read and write both high counts as a write with no read return
    acc_read  = acc_valid & ~acc_write;
  end

`ifdef ONCHIP_MEM_ARBITER_RANGE_CHECK_EN
  logic tag_oor_reg;
  logic range_err_reg;

  // An access at or beyond DEPTH is acknowledged but kept off the RAM
  always_comb begin
    acc_oor = acc_valid & (32'(sel_address) >= 32'(DEPTH));
  end

  // Remember whether the read in flight was blocked; range_err is sticky
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_oor_reg   <= 1'b0;
      range_err_reg <= 1'b0;
    end else begin
      tag_oor_reg <= acc_read & acc_oor;
      if (acc_oor) begin
        range_err_reg <= 1'b1;
      end
    end
  end

  // A blocked read returns a recognisable poison word
  always_comb begin
    ret_data  = tag_oor_reg ? DATA_W'(32'hDEADBEEF) : ram_readdata;
    range_err = range_err_reg;
  end
`else
  // Without range checking, every address goes straight to the RAM (aliasing)
  always_comb begin
    acc_oor  = 1'b0;
    ret_data = ram_readdata;
  end
`endif

  // RAM drive happens in the accept cycle; fields are zeroed when nobody wins
  always_comb begin
    ram_address    = sel_address;
    ram_byteenable = sel_byteenable;
    ram_writedata  = sel_writedata;
    ram_chipselect = acc_valid & ~acc_oor;
    ram_write      = acc_write & ~acc_oor;
    ram_clken      = 1'b1;
  end

  // Tag each accepted read with its owner; advance the round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid_reg  <= 1'b0;
      tag_owner_reg  <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      tag_valid_reg <= acc_read;
      if (acc_read) begin
        tag_owner_reg <= grant1;
      end
      if (acc_valid) begin
        last_grant_reg <= grant1;
      end
    end
  end

  // Master-side responses: both buses share the data, valid picks the owner
  always_comb begin
    m0_waitrequest   = ~grant0;
    m1_waitrequest   = ~grant1;
    m0_readdata      = ret_data;
    m1_readdata      = ret_data;
    m0_readdatavalid = tag_valid_reg & ~tag_owner_reg;
    m1_readdatavalid = tag_valid_reg & tag_owner_reg;
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle-latency RAM.
// Inputs change 1 ns after the rising edge and outputs are sampled on the falling edge.
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata;
  logic [31:0] ram_readdata = '0;
`ifdef ONCHIP_MEM_ARBITER_RANGE_CHECK_EN
  logic        range_err;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
`ifdef ONCHIP_MEM_ARBITER_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  // Behavioural single-port RAM: byte-lane writes, registered read data
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  // One line per transaction issued to the RAM
  always @(negedge clk) begin
    if (ram_chipselect)
      $display("[TB] t=%0t ram %s addr=0x%03h be=%b wdata=0x%08h", $time,
               ram_write ? "WR" : "RD", ram_address, ram_byteenable, ram_writedata);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_address = '0; m1_address = '0; m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    m0_read = 1'b1; m0_address = 13'h010;
    m1_write = 1'b1; m1_address = 13'h011; m1_byteenable = 4'hF;
    @(negedge clk);
    tests_run++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
      tests_failed++;
      $display("FAIL reset_wait got=%b exp=11", {m0_waitrequest, m1_waitrequest});
    end
    tests_run++;
    if ({ram_chipselect, ram_write, m0_readdatavalid, m1_readdatavalid} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_strobes got=%b exp=0000",
               {ram_chipselect, ram_write, m0_readdatavalid, m1_readdatavalid});
    end
`ifdef ONCHIP_MEM_ARBITER_RANGE_CHECK_EN
    tests_run++;
    if (range_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_range_err got=%b exp=0", range_err);
    end
`endif
    next_cycle();
    reset_n = 1'b1;
    idle_all();
    @(negedge clk);
    tests_run++;
    if ({m0_waitrequest, m1_waitrequest, ram_chipselect, ram_clken} !== 4'b1101 ||
        ram_address !== 13'h0) begin
      tests_failed++;
      $display("FAIL idle_outputs got=%b addr=0x%h exp=1101 addr=0",
               {m0_waitrequest, m1_waitrequest, ram_chipselect, ram_clken}, ram_address);
    end
  endtask

  task automatic test_write_read();
    next_cycle();
    m0_write = 1'b1; m0_address = 13'h010; m0_writedata = 32'h12345678; m0_byteenable = 4'hF;
    @(negedge clk);
    tests_run++;
    if ({m0_waitrequest, ram_chipselect, ram_write} !== 3'b011 || ram_address !== 13'h010) begin
      tests_failed++;
      $display("FAIL wr_accept got=%b addr=0x%h exp=011 addr=0x010",
               {m0_waitrequest, ram_chipselect, ram_write}, ram_address);
    end
    next_cycle();
    m0_write = 1'b0; m0_read = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({m0_waitrequest, ram_chipselect, ram_write, m0_readdatavalid} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rd_accept got=%b exp=0100",
               {m0_waitrequest, ram_chipselect, ram_write, m0_readdatavalid});
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if (m0_readdatavalid !== 1'b1 || m1_readdatavalid !== 1'b0 || m0_readdata !== 32'h12345678) begin
      tests_failed++;
      $display("FAIL rd_return v0=%b v1=%b data=0x%h exp v0=1 v1=0 data=0x12345678",
               m0_readdatavalid, m1_readdatavalid, m0_readdata);
    end
    next_cycle();
    @(negedge clk);
    tests_run++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rd_single_valid got=%b exp=00", {m0_readdatavalid, m1_readdatavalid});
    end
  endtask

  // The previous accepted access was by m0, so only the reset value of the
  // pointer can make m0 win the first tie here.
  task automatic test_round_robin();
    logic exp_m0, prev_m0;
    mem[13'h040] = 32'hA0A0_0040;
    mem[13'h041] = 32'hB1B1_0041;
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    m0_read = 1'b1; m0_address = 13'h040;
    m1_read = 1'b1; m1_address = 13'h041;
    prev_m0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_m0 = (i % 2 == 0);
      @(negedge clk);
      tests_run++;
      if (m0_waitrequest !== !exp_m0 || m1_waitrequest !== exp_m0 ||
          ram_address !== (exp_m0 ? 13'h040 : 13'h041)) begin
        tests_failed++;
        $display("FAIL rr_grant cyc=%0d wait=%b addr=0x%h exp wait=%b", i,
                 {m0_waitrequest, m1_waitrequest}, ram_address, {!exp_m0, exp_m0});
      end
      if (i > 0) begin
        tests_run++;
        if (m0_readdatavalid !== prev_m0 || m1_readdatavalid !== !prev_m0 ||
            m0_readdata !== (prev_m0 ? 32'hA0A0_0040 : 32'hB1B1_0041)) begin
          tests_failed++;
          $display("FAIL rr_return cyc=%0d v=%b data=0x%h exp v=%b", i,
                   {m0_readdatavalid, m1_readdatavalid}, m0_readdata, {prev_m0, !prev_m0});
        end
      end
      prev_m0 = exp_m0;
      next_cycle();
    end
    idle_all();
    @(negedge clk);
    tests_run++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b01 || m1_readdata !== 32'hB1B1_0041) begin
      tests_failed++;
      $display("FAIL rr_last_return v=%b data=0x%h exp v=01 data=0xb1b10041",
               {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
    end
  endtask

  task automatic test_byteenable();
    next_cycle();
    m0_write = 1'b1; m0_address = 13'h020; m0_writedata = 32'hAABBCCDD; m0_byteenable = 4'hF;
    next_cycle();
    idle_all();
    m1_write = 1'b1; m1_address = 13'h020; m1_writedata = 32'h0000EE00; m1_byteenable = 4'b0010;
    @(negedge clk);
    tests_run++;
    if (m1_waitrequest !== 1'b0 || ram_byteenable !== 4'b0010 || ram_writedata !== 32'h0000EE00) begin
      tests_failed++;
      $display("FAIL be_accept wait=%b be=%b wd=0x%h exp wait=0 be=0010 wd=0x0000ee00",
               m1_waitrequest, ram_byteenable, ram_writedata);
    end
    next_cycle();
    idle_all();
    m0_read = 1'b1; m0_address = 13'h020;
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hAABBEEDD) begin
      tests_failed++;
      $display("FAIL be_merge v=%b data=0x%h exp v=1 data=0xaabbeedd", m0_readdatavalid, m0_readdata);
    end
  endtask

  task automatic test_reset_inflight();
    next_cycle();
    m1_read = 1'b1; m1_address = 13'h041;
    @(negedge clk);
    tests_run++;
    if (m1_waitrequest !== 1'b0) begin
      tests_failed++;
      $display("FAIL inflight_accept wait=%b exp=0", m1_waitrequest);
    end
    next_cycle();
    reset_n = 1'b0;
    idle_all();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) reset_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
        tests_failed++;
        $display("FAIL inflight_lost cyc=%0d v=%b exp=00", i, {m0_readdatavalid, m1_readdatavalid});
      end
      next_cycle();
    end
    m0_read = 1'b1; m0_address = 13'h040;
    m1_read = 1'b1; m1_address = 13'h041;
    @(negedge clk);
    tests_run++;
    if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin
      tests_failed++;
      $display("FAIL post_reset_tie got=%b exp=01", {m0_waitrequest, m1_waitrequest});
    end
    next_cycle();
    idle_all();
  endtask

  task automatic test_read_write_both();
    next_cycle();
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 13'h030;
    m0_writedata = 32'h00000055; m0_byteenable = 4'hF;
    @(negedge clk);
    tests_run++;
    if ({m0_waitrequest, ram_chipselect, ram_write} !== 3'b011) begin
      tests_failed++;
      $display("FAIL rw_is_write got=%b exp=011", {m0_waitrequest, ram_chipselect, ram_write});
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL rw_no_valid got=%b exp=00", {m0_readdatavalid, m1_readdatavalid});
    end
    next_cycle();
    m0_read = 1'b1; m0_address = 13'h030;
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h00000055) begin
      tests_failed++;
      $display("FAIL rw_readback v=%b data=0x%h exp v=1 data=0x00000055", m0_readdatavalid, m0_readdata);
    end
  endtask

`ifdef ONCHIP_MEM_ARBITER_RANGE_CHECK_EN
  task automatic test_range_check();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (range_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL range_err_clear got=%b exp=0", range_err);
    end
    next_cycle();
    m0_read = 1'b1; m0_address = 13'd5120;
    @(negedge clk);
    tests_run++;
    if ({m0_waitrequest, ram_chipselect, ram_write} !== 3'b000) begin
      tests_failed++;
      $display("FAIL oor_accept got=%b exp=000", {m0_waitrequest, ram_chipselect, ram_write});
    end
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || range_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_return v=%b data=0x%h err=%b exp v=1 data=0xdeadbeef err=1",
               m0_readdatavalid, m0_readdata, range_err);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    tests_run++;
    if (range_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL range_err_sticky got=%b exp=1", range_err);
    end
  endtask
`endif

  initial begin
    for (int a = 0; a < 8192; a++) mem[a] = 32'h0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_byteenable();
    test_reset_inflight();
    test_read_write_both();
`ifdef ONCHIP_MEM_ARBITER_RANGE_CHECK_EN
    test_range_check();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port 32-bit on-chip RAM (5120 words, 13-bit word address, 4 byte lanes, 1-cycle read latency) between two Avalon-MM-style masters.
- Typical masters: the Nios V data port and a DMA/accelerator engine.
- Sits between the two masters and the RAM's s1 slave port.
- Provides waitrequest back-pressure and pipelined readdatavalid so both masters see a clean, non-blocking interface.

Parameters:
- ADDR_W, 13, word address width presented to the RAM.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- DEPTH, 5120, number of valid RAM words; used only by the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address / m1_address  in  ADDR_W  requester word address.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_byteenable / m1_byteenable  in  DATA_W/8  write byte lanes.
- m0_writedata / m1_writedata  in  DATA_W  write data.
- m0_waitrequest / m1_waitrequest  out  1  high = request not accepted this cycle.
- m0_readdata / m1_readdata  out  DATA_W  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle.
- ram_address  out  ADDR_W  to RAM address.
- ram_byteenable  out  DATA_W/8  to RAM byteenable.
- ram_chipselect  out  1  to RAM chipselect.
- ram_write  out  1  to RAM write.
- ram_writedata  out  DATA_W  to RAM writedata.
- ram_clken  out  1  to RAM clken; tied high.
- ram_readdata  in  DATA_W  from RAM readdata; valid the cycle after a read is issued.

Behaviour:
- Request: mN_req = mN_read | mN_write. If read and write are both high, the access is a write; no readdatavalid is produced.
- Arbitration: combinational each cycle from the current requests and the registered last_grant pointer.
  - Only one requester active: it wins.
  - Both active: the one not equal to last_grant wins.
  - last_grant updates on every accepted transfer.
- Acceptance:
  - Winner: mN_waitrequest=0 in the same cycle; the transfer completes that cycle (zero-wait when uncontended).
  - Loser and idle masters: waitrequest=1 while requesting. Idle (not requesting): waitrequest=1.
  - A waiting master must hold its signals stable; the arbiter does not latch them.
- RAM drive, same cycle as accept:
  - ram_chipselect=1; ram_address, ram_byteenable and ram_writedata come from the winner.
  - ram_write=1 only for a write.
  - With no winner: ram_chipselect=0, ram_write=0, other RAM outputs 0.
- Read return:
  - Registered tag {valid, owner} captures an accepted read.
  - Next cycle: mOwner_readdatavalid=1 and mOwner_readdata=ram_readdata.
  - Non-owner readdatavalid=0; both readdata buses carry ram_readdata (qualified by valid).
  - Fixed read latency 1; throughput 1 access/cycle total.
  - Back-to-back reads from alternating masters return in issue order, one per cycle.
- Read-after-write to the same address in consecutive cycles returns the new data (RAM is written before the read is issued).
- Reset (asserted at any time, including with a read in flight):
  - Tag valid=0, so no readdatavalid for the lost read.
  - last_grant=1, so m0 wins the first contention.
  - All waitrequest=1 and all RAM strobes 0 while reset_n=0.
- Addresses are passed unmodified; out-of-range handling exists only with the optional feature.

Optional Feature:
- Macro: ONCHIP_MEM_ARBITER_RANGE_CHECK_EN.
- Defined:
  - An accepted access with address >= DEPTH is completed normally towards the master (waitrequest=0), but ram_chipselect=0 and ram_write=0.
  - A read returns readdatavalid with readdata=32'hDEADBEEF on the next cycle.
  - Sticky output range_err (1 bit, reset 0) sets on the first such access; cleared only by reset.
- Undefined: no range_err port; addresses pass straight to the RAM, which aliases out-of-range accesses.

Test Plan:
- m0 write addr 0x010 data 0x12345678 be 4'hF, then read 0x010 -> waitrequest=0 both cycles; m0_readdatavalid=1 one cycle after the read with 0x12345678; m1 idle, never valid.
- m0 and m1 both read continuously for 6 cycles after reset -> grants m0,m1,m0,m1,m0,m1; each readdatavalid appears one cycle after its grant; loser sees waitrequest=1.
- Write 0xAABBCCDD to 0x020, then m1 write be 4'b0010 data 0x0000EE00 -> readback 0xAABBEEDD.
- m1 read accepted, reset_n pulsed low the next cycle -> no readdatavalid is ever produced for that read; after release m0 wins the first contention.
- m0 read+write both high, address 0x030, data 0x55 -> ram_write=1, no m0_readdatavalid; a later read of 0x030 returns 0x55.
- With the macro defined, m0 read address 5120 -> ram_chipselect=0, readdata 0xDEADBEEF with valid next cycle, range_err=1 and stays 1.
